// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_pkg
// Description : Shared types and constants for the DigiLock keypad sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        ENTRY   = 3'd2,
        CHECK   = 3'd3,
        WRONG   = 3'd4,
        OPEN    = 3'd5,
        LOCKOUT = 3'd6
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam int         CODE_W    = 16;

    // Width of the shared OPEN/LOCKOUT down-counter.
    function automatic int timer_width(input int open_cycles, input int lock_cycles);
        int longest;
        longest = (open_cycles > lock_cycles) ? open_cycles : lock_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/criptografia.sv
`default_nettype none
// ============================================================================
// Module      : criptografia
// Description : Combinational digit encoder, 4-bit digit in, 16-bit code out.
// Revision    : 1.0 - initial release
// ============================================================================
module criptografia
    import lock_pkg::*;
(
    input  logic [3:0]        digit_in,
    output logic [CODE_W-1:0] code_out
);

    // The inverted nibble alone makes the mapping injective over all 16 inputs.
    always_comb begin
        code_out = {digit_in ^ 4'hA, digit_in + 4'h7, ~digit_in, {digit_in[0], digit_in[3:1]}};
    end

endmodule
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lock_sequencer
// Description : DigiLock keypad sequencer: password init, entry buffering,
//               word-serial compare, open/error/lockout status.
//               Optional in-OPEN reprogramming via LOCK_REPROGRAM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int              NDIG        = 4,
    parameter logic [4*NDIG-1:0] DEFAULT_PW = 16'h1234,
    parameter int              MAX_TRIES   = 3,
    parameter int              OPEN_CYCLES = 500,
    parameter int              LOCK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       enter,
    input  logic       clear,
    output logic       ready,
    output logic [2:0] count,
    output logic       open,
    output logic       error,
    output logic       locked_out
);

    localparam int c_IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int c_TIMER_W = timer_width(OPEN_CYCLES, LOCK_CYCLES);
    localparam int c_TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [c_IDX_W-1:0]   c_IDX_LAST = c_IDX_W'(NDIG - 1);
    localparam logic [2:0]           c_FULL     = 3'(NDIG);
    localparam logic [c_TRY_W-1:0]   c_TRY_MAX  = c_TRY_W'(MAX_TRIES);
    localparam logic [c_TIMER_W-1:0] c_OPEN_LD  = c_TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LD  = c_TIMER_W'(LOCK_CYCLES - 1);

    state_t                r_state, w_next;
    logic [c_IDX_W-1:0]    r_idx;
    logic [2:0]            r_count;
    logic [c_TRY_W-1:0]    r_tries;
    logic [c_TIMER_W-1:0]  r_timer;
    logic                  r_mis;
    logic                  r_digit_err;
    logic [CODE_W-1:0]     r_pw_mem  [NDIG];
    logic [CODE_W-1:0]     r_ent_mem [NDIG];

    logic [3:0]            w_enc_in;
    logic [CODE_W-1:0]     w_code;
    logic                  w_full, w_digit_ok, w_digit_bad, w_mis_acc, w_timer_done;
    logic                  w_keypad_on, w_reprog;
    logic [c_TRY_W-1:0]    w_tries_inc;

    assign w_enc_in = (r_state == INIT) ? DEFAULT_PW[4*(NDIG-1-int'(r_idx)) +: 4] : digit;

    criptografia u_enc (
        .digit_in (w_enc_in),
        .code_out (w_code)
    );

    assign w_full       = (r_count == c_FULL);
    assign w_digit_ok   = digit_valid && !clear && !enter && (digit <= DIGIT_MAX) && !w_full;
    assign w_digit_bad  = digit_valid && !clear && !enter && (digit >  DIGIT_MAX);
    assign w_mis_acc    = r_mis || (r_ent_mem[r_idx] != r_pw_mem[r_idx]);
    assign w_timer_done = (r_timer == '0);
    assign w_tries_inc  = r_tries + 1'b1;

`ifdef LOCK_REPROGRAM_EN
    assign w_keypad_on = (r_state == IDLE) || (r_state == ENTRY) || (r_state == OPEN);
    assign w_reprog    = (r_state == OPEN) && enter && !clear && w_full;
`else
    assign w_keypad_on = (r_state == IDLE) || (r_state == ENTRY);
    assign w_reprog    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= INIT;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:        if (r_idx == c_IDX_LAST) w_next = IDLE;
            IDLE, ENTRY: begin
                if (clear)           w_next = IDLE;
                else if (enter)      w_next = w_full ? CHECK : WRONG;
                else if (w_digit_ok) w_next = ENTRY;
            end
            CHECK:       if (r_idx == c_IDX_LAST) w_next = w_mis_acc ? WRONG : OPEN;
            WRONG:       w_next = (w_tries_inc >= c_TRY_MAX) ? LOCKOUT : IDLE;
            OPEN:        if (!w_reprog && w_timer_done) w_next = IDLE;
            LOCKOUT:     if (w_timer_done) w_next = IDLE;
            default:     w_next = INIT;
        endcase
    end

    always_comb begin
        ready      = w_keypad_on;
        count      = r_count;
        open       = (r_state == OPEN);
        locked_out = (r_state == LOCKOUT);
        error      = (r_state == WRONG) || r_digit_err;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_count     <= '0;
            r_tries     <= '0;
            r_timer     <= '0;
            r_mis       <= 1'b0;
            r_digit_err <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                r_pw_mem[i]  <= '0;
                r_ent_mem[i] <= '0;
            end
        end else begin
            r_digit_err <= w_keypad_on && w_digit_bad;
            r_mis       <= (r_state == CHECK) ? w_mis_acc : 1'b0;
            // r_idx walks the default password in INIT and the compare in CHECK.
            r_idx <= ((r_state == INIT || r_state == CHECK) && r_idx != c_IDX_LAST) ? r_idx + 1'b1 : '0;

            if (r_state == INIT) r_pw_mem[r_idx] <= w_code;
            if (w_reprog) begin
                for (int i = 0; i < NDIG; i++) r_pw_mem[i] <= r_ent_mem[i];
            end

            if (r_state == WRONG || (r_state == CHECK && w_next == OPEN) ||
                (r_state == OPEN && w_next == IDLE)) begin
                r_count <= '0;
            end else if (w_keypad_on) begin
                if (clear || w_reprog) begin
                    r_count <= '0;
                end else if (w_digit_ok) begin
                    r_ent_mem[r_count[c_IDX_W-1:0]] <= w_code;
                    r_count <= r_count + 1'b1;
                end
            end

            if (r_state == WRONG)                                      r_tries <= w_tries_inc;
            else if (r_state == CHECK && w_next == OPEN)               r_tries <= '0;
            else if (r_state == LOCKOUT && w_timer_done)               r_tries <= '0;

            if (w_next == OPEN && (r_state != OPEN || w_reprog))       r_timer <= c_OPEN_LD;
            else if (w_next == LOCKOUT && r_state != LOCKOUT)          r_timer <= c_LOCK_LD;
            else if (!w_timer_done)                                    r_timer <= r_timer - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_sequencer
// Description : Directed self-checking bench for lock_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] digit;
    logic       digit_valid, enter, clear;
    logic       ready, open, error, locked_out;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int k, n;

    lock_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .digit       (digit),
        .digit_valid (digit_valid),
        .enter       (enter),
        .clear       (clear),
        .ready       (ready),
        .count       (count),
        .open        (open),
        .error       (error),
        .locked_out  (locked_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        digit = d; digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic do_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
        do_enter();
    endtask

    // Counts ticks from the enter edge until open or error rises.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!open && !error && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_open_end(output int cycles);
        cycles = 0;
        while (open && cycles < 700) begin
            cycles++;
            tick();
        end
    endtask

    task automatic init_sequence(input string tag);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk({tag, "_ready_before"}, ready, 0);
        tick();
        chk({tag, "_ready_at_ndig1"}, ready, 1);
        chk({tag, "_count"}, count, 0);
    endtask

    initial begin
        reset_n = 1'b0; digit = '0; digit_valid = 0; enter = 0; clear = 0;
        #3;
        chk("rst_outputs", {ready, count, open, error, locked_out}, 0);
        tick(); tick();
        init_sequence("init");

        // Correct password opens after a fixed 4-cycle compare
        enter_code(16'h1234);
        chk("check_ready_low", ready, 0);
        wait_result(k);
        chk("check_latency", k, 4);
        chk("open_high", open, 1);
        wait_open_end(n);
        chk("open_duration", n, 500);
        chk("post_open_count", count, 0);
        chk("post_open_ready", ready, 1);

        // Illegal digit
        press(4'hA);
        chk("bad_digit_error", error, 1);
        chk("bad_digit_count", count, 0);
        tick();
        chk("bad_digit_pulse_end", error, 0);

        // Saturation
        press(1); press(2); press(3); press(4); press(5);
        chk("count_saturate", count, 4);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_count", count, 0);

        // Simultaneous strobes: clear wins
        press(1); press(2);
        chk("two_digits", count, 2);
        clear = 1; enter = 1; digit_valid = 1; digit = 4'd3;
        tick();
        clear = 0; enter = 0; digit_valid = 0;
        chk("prio_count", count, 0);
        chk("prio_error", error, 0);
        tick();
        chk("prio_no_check", ready, 1);
        chk("prio_error2", error, 0);

        // Three wrong attempts lead to lockout
        for (int t = 0; t < 3; t++) begin
            enter_code(16'h1235);
            wait_result(k);
            chk("wrong_latency", k, 4);
            chk("wrong_error", error, 1);
            chk("wrong_open", open, 0);
            tick();
            chk("wrong_pulse_end", error, 0);
            chk("lockout_state", locked_out, (t == 2) ? 1 : 0);
        end

        // Keypad hammered during lockout must be ignored
        n = 0;
        while (locked_out && n < 1100) begin
            n++;
            digit = 4'd1; digit_valid = 1'b1; enter = n[0];
            if (n == 500) begin
                chk("lockout_ready", ready, 0);
                chk("lockout_count", count, 0);
                chk("lockout_error", error, 0);
            end
            tick();
        end
        digit_valid = 0; enter = 0;
        chk("lockout_duration", n, 1000);
        chk("post_lock_ready", ready, 1);
        chk("post_lock_count", count, 0);

        // Tries cleared by lockout: one wrong attempt does not relock
        enter_code(16'h9999);
        wait_result(k);
        chk("retry_error", error, 1);
        tick();
        chk("retry_no_lock", locked_out, 0);

        // Reset during OPEN aborts it and reruns INIT
        enter_code(16'h1234);
        wait_result(k);
        chk("open_before_rst", open, 1);
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("rst_open_drop", open, 0);
        chk("rst_ready", ready, 0);
        tick();
        init_sequence("reinit");

        // Keypad activity during OPEN
        enter_code(16'h1234);
        wait_result(k);
        chk("open_again", open, 1);
        press(9); press(8); press(7); press(6);
`ifdef LOCK_REPROGRAM_EN
        chk("open_entry_count", count, 4);
`else
        chk("open_entry_count", count, 0);
`endif
        do_enter();
        wait_open_end(n);
`ifdef LOCK_REPROGRAM_EN
        chk("reprog_open_restart", n, 500);
`else
        chk("open_ignore_keys", n, 495);
`endif

        enter_code(16'h9876);
        wait_result(k);
`ifdef LOCK_REPROGRAM_EN
        chk("new_pw_open", open, 1);
        wait_open_end(n);
        enter_code(16'h1234);
        wait_result(k);
        chk("old_pw_error", error, 1);
        chk("old_pw_open", open, 0);
`else
        chk("other_pw_error", error, 1);
        chk("other_pw_open", open, 0);
`endif
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
